// File: rtl/mmio_uart_tx_arbiter_pkg.sv
// Shared basic types and arbiter state encoding for the hart-to-UART TX MMIO path.
package mmio_uart_tx_arbiter_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] UIntX;
  typedef logic [7:0]      UInt8;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } UartArbState;

  localparam UInt8 LINE_END = 8'h0A;

  function automatic logic is_line_end(input UIntX wdata);
    return wdata[7:0] == LINE_END;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_arbiter_rr_picker.sv
// Round-robin picker: first asserted valid bit at or above ptr, wrapping to 0.
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] index
);

  int j;

  // Walk from the farthest candidate back to ptr so the nearest one wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (valid[j]) begin
        found = 1'b1;
        index = IW'(j);
      end
    end
  end

endmodule

// File: rtl/mmio_uart_tx_arbiter.sv
// Shares one UART TX MMIO slave among NUM_REQ harts; a writer keeps the line until
// it sends LF or goes quiet for LOCK_TIMEOUT cycles.
//
// state  | meaning
// IDLE   | round-robin among all valid requesters, starting at rr_ptr
// LOCKED | only owner is served; timer counts cycles without an owner handshake
module mmio_uart_tx_arbiter
  import mmio_uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  output logic [NUM_REQ-1:0] req_ready,
  input  logic [NUM_REQ-1:0] req_valid,
  input  UIntX               req_addr   [NUM_REQ],
  input  logic [NUM_REQ-1:0] req_wen,
  input  UIntX               req_wdata  [NUM_REQ],
  output logic [NUM_REQ-1:0] resp_valid,
  output UIntX               resp_rdata [NUM_REQ],
  input  logic               out_req_ready,
  output logic               out_req_valid,
  output UIntX               out_req_addr,
  output logic               out_req_wen,
  output UIntX               out_req_wdata,
  input  logic               out_resp_valid,
  input  UIntX               out_resp_rdata
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(LOCK_TIMEOUT + 1);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [TMR_W-1:0] tmr_t;

  UartArbState state_q, state_d;
  idx_t        owner_q, owner_d;
  idx_t        rr_ptr_q, rr_ptr_d;
  tmr_t        timer_q, timer_d;

  logic pick_found;
  idx_t pick_idx;
  idx_t sel;
  logic sel_found;
  logic hs;

  function automatic idx_t next_idx(input idx_t i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + idx_t'(1);
  endfunction

  rr_picker #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_rr_picker (
    .valid (req_valid),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .index (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      timer_q  <= timer_d;
    end
  end

  always_comb begin
    out_req_valid = 1'b0;
    out_req_addr  = '0;
    out_req_wen   = 1'b0;
    out_req_wdata = '0;
    req_ready     = '0;
    resp_valid    = '0;
    hs            = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) resp_rdata[i] = out_resp_rdata;

    if (state_q == LOCKED) begin
      sel       = owner_q;
      sel_found = req_valid[owner_q];
    end else begin
      sel       = pick_idx;
      sel_found = pick_found;
    end

    // Reset masks everything so nothing leaks downstream before state is cleared.
    if (!reset && sel_found) begin
      out_req_valid   = 1'b1;
      out_req_addr    = req_addr[sel];
      out_req_wen     = req_wen[sel];
      out_req_wdata   = req_wdata[sel];
      req_ready[sel]  = out_req_ready;
      hs              = out_req_ready;
      resp_valid[sel] = out_req_ready & out_resp_valid;
    end

    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    timer_d  = timer_q;

    if (hs && out_req_wen && is_line_end(out_req_wdata)) begin
      state_d  = IDLE;
      rr_ptr_d = next_idx(sel);
      timer_d  = '0;
    end else if (hs && out_req_wen) begin
      state_d = LOCKED;
      owner_d = sel;
      timer_d = '0;
    end else if (hs) begin
      if (state_q == LOCKED) timer_d = '0;
    end else if (state_q == LOCKED) begin
      if (timer_q == tmr_t'(LOCK_TIMEOUT - 1)) begin
        state_d  = IDLE;
        rr_ptr_d = next_idx(owner_q);
        timer_d  = '0;
      end else begin
        timer_d = timer_q + tmr_t'(1);
      end
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx_arbiter.sv
// Scoreboard bench: every expected downstream transaction is queued when driven and
// matched against the observed handshake; grant timing is checked cycle by cycle.
module tb_mmio_uart_tx_arbiter;
  import mmio_uart_tx_arbiter_pkg::*;

  localparam int NR = 2;
  localparam int LT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req_ready, req_valid, req_wen, resp_valid;
  UIntX          req_addr [NR];
  UIntX          req_wdata[NR];
  UIntX          resp_rdata[NR];
  logic          out_req_ready, out_req_valid, out_req_wen, out_resp_valid;
  UIntX          out_req_addr, out_req_wdata, out_resp_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  logic [55:0] sb_q[$];

  mmio_uart_tx_arbiter #(.NUM_REQ(NR), .LOCK_TIMEOUT(LT)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_ready      (req_ready),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_wen        (req_wen),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .out_req_ready  (out_req_ready),
    .out_req_valid  (out_req_valid),
    .out_req_addr   (out_req_addr),
    .out_req_wen    (out_req_wen),
    .out_req_wdata  (out_req_wdata),
    .out_resp_valid (out_resp_valid),
    .out_resp_rdata (out_resp_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [55:0] pack_tx(input logic [7:0] ready, input UIntX addr,
                                          input logic wen, input UIntX wdata);
    return {ready, addr[7:0], 7'b0, wen, wdata};
  endfunction

  task automatic expect_tx(input int idx, input logic wen, input UIntX wdata);
    sb_q.push_back(pack_tx(8'(1 << idx), req_addr[idx], wen, wdata));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!reset && out_req_valid && out_req_ready) begin
      if (sb_q.size() == 0)
        check_eq("sb_extra", 64'(out_req_wdata), 64'hFFFF_FFFF_FFFF_FFFF);
      else
        check_eq("sb_tx", 64'(pack_tx(8'(req_ready), out_req_addr, out_req_wen, out_req_wdata)),
                 64'(sb_q.pop_front()));
    end
  end

  initial begin
    reset          = 1'b1;
    req_valid      = 2'b11;
    req_wen        = 2'b11;
    req_addr[0]    = 32'h1000_0000;
    req_addr[1]    = 32'h1000_0004;
    req_wdata[0]   = 32'h41;
    req_wdata[1]   = 32'h41;
    out_req_ready  = 1'b1;
    out_resp_valid = 1'b1;
    out_resp_rdata = 32'h0;

    // Outputs are masked while reset is held.
    settle();
    check_eq("rst_out_valid", 64'(out_req_valid), 64'd0);
    check_eq("rst_req_ready", 64'(req_ready), 64'd0);
    check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
    next_cycle();
    reset          = 1'b0;
    req_valid      = 2'b00;
    out_resp_valid = 1'b0;
    settle();
    check_eq("rst_state", 64'(dut.state_q), 64'(IDLE));
    check_eq("idle_no_valid", 64'(out_req_valid), 64'd0);

    // Both request: req 0 wins and locks.
    next_cycle();
    req_valid = 2'b11;
    expect_tx(0, 1'b1, 32'h41);
    settle();
    check_eq("first_grant", 64'(req_ready), 64'b01);
    next_cycle();
    check_eq("lock_state", 64'(dut.state_q), 64'(LOCKED));
    check_eq("lock_owner", 64'(dut.owner_q), 64'd0);

    // Owner sends "Hi\n" while req 1 waits.
    req_wdata[1] = 32'h42;
    req_wdata[0] = 32'h48;
    expect_tx(0, 1'b1, 32'h48);
    settle();
    check_eq("line_h", 64'(req_ready), 64'b01);
    next_cycle();
    req_wdata[0] = 32'h69;
    expect_tx(0, 1'b1, 32'h69);
    settle();
    check_eq("line_i", 64'(req_ready), 64'b01);
    next_cycle();
    req_wdata[0] = 32'h0A;
    expect_tx(0, 1'b1, 32'h0A);
    settle();
    check_eq("line_lf", 64'(req_ready), 64'b01);
    next_cycle();
    check_eq("lf_state", 64'(dut.state_q), 64'(IDLE));
    check_eq("lf_rr_ptr", 64'(dut.rr_ptr_q), 64'd1);
    req_wdata[0] = 32'h41;
    expect_tx(1, 1'b1, 32'h42);
    settle();
    check_eq("rr_grant1", 64'(req_ready), 64'b10);
    next_cycle();
    check_eq("lock_owner1", 64'(dut.owner_q), 64'd1);

    // Reset mid-line with owner 1.
    reset = 1'b1;
    settle();
    check_eq("rst2_out_valid", 64'(out_req_valid), 64'd0);
    check_eq("rst2_req_ready", 64'(req_ready), 64'd0);
    next_cycle();
    reset = 1'b0;
    check_eq("rst2_state", 64'(dut.state_q), 64'(IDLE));
    check_eq("rst2_rr_ptr", 64'(dut.rr_ptr_q), 64'd0);
    expect_tx(0, 1'b1, 32'h41);
    settle();
    check_eq("rst2_grant0", 64'(req_ready), 64'b01);
    next_cycle();

    // Owner 0 goes quiet: lock holds for LT idle cycles, then req 1 gets through.
    req_valid    = 2'b10;
    req_wdata[1] = 32'h0A;
    expect_tx(1, 1'b1, 32'h0A);
    for (int k = 1; k <= LT; k++) begin
      settle();
      check_eq($sformatf("to_hold%0d", k), 64'(req_ready), 64'd0);
      next_cycle();
    end
    settle();
    check_eq("to_grant1", 64'(req_ready), 64'b10);
    next_cycle();
    check_eq("to_state", 64'(dut.state_q), 64'(IDLE));
    check_eq("to_rr_ptr", 64'(dut.rr_ptr_q), 64'd0);

    // Downstream stalls: request stays presented, nothing accepted.
    req_valid      = 2'b01;
    out_req_ready  = 1'b0;
    out_resp_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      settle();
      check_eq($sformatf("stall_valid%0d", k), 64'(out_req_valid), 64'd1);
      check_eq($sformatf("stall_data%0d", k), 64'(out_req_wdata), 64'h41);
      check_eq($sformatf("stall_ready%0d", k), 64'(req_ready), 64'd0);
      check_eq($sformatf("stall_resp%0d", k), 64'(resp_valid), 64'd0);
      next_cycle();
    end
    out_req_ready = 1'b1;
    expect_tx(0, 1'b1, 32'h41);
    settle();
    check_eq("stall_release", 64'(req_ready), 64'b01);
    check_eq("stall_resp", 64'(resp_valid), 64'b01);
    next_cycle();
    check_eq("stall_lock", 64'(dut.state_q), 64'(LOCKED));
    out_resp_valid = 1'b0;
    req_wdata[0]   = 32'h0A;
    expect_tx(0, 1'b1, 32'h0A);
    next_cycle();
    check_eq("stall_unlock", 64'(dut.state_q), 64'(IDLE));
    check_eq("stall_rr_ptr", 64'(dut.rr_ptr_q), 64'd1);

    // Read by req 1 in IDLE.
    req_valid      = 2'b10;
    req_wen        = 2'b01;
    req_addr[1]    = 32'h1000_0010;
    req_wdata[1]   = 32'h55;
    out_resp_valid = 1'b1;
    out_resp_rdata = 32'hDEAD_BEEF;
    expect_tx(1, 1'b0, 32'h55);
    settle();
    check_eq("rd_resp_valid", 64'(resp_valid), 64'b10);
    check_eq("rd_rdata0", 64'(resp_rdata[0]), 64'hDEAD_BEEF);
    check_eq("rd_rdata1", 64'(resp_rdata[1]), 64'hDEAD_BEEF);
    next_cycle();
    req_valid      = 2'b00;
    out_resp_valid = 1'b0;
    check_eq("rd_state", 64'(dut.state_q), 64'(IDLE));
    check_eq("rd_rr_ptr", 64'(dut.rr_ptr_q), 64'd1);

    settle();
    check_eq("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx_arbiter.md
MMIO_UART_TX_ARBITER -- requirements
Module: mmio_uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of MMIO requesters sharing one UART TX port (range 2..8).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 1024, idle cycles after which a line lock is released (range 1..65535).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports req_ready[NUM_REQ]  output  1  per-requester accept.
REQ-006 SHALL have ports req_valid[NUM_REQ]  input  1; req_addr[NUM_REQ]  input  UIntX; req_wen[NUM_REQ]  input  1; req_wdata[NUM_REQ]  input  UIntX.
REQ-007 SHALL have ports resp_valid[NUM_REQ]  output  1; resp_rdata[NUM_REQ]  output  UIntX.
REQ-008 SHALL have downstream ports out_req_ready  input  1; out_req_valid  output  1; out_req_addr  output  UIntX; out_req_wen  output  1; out_req_wdata  output  UIntX; out_resp_valid  input  1; out_resp_rdata  input  UIntX.

Function
REQ-009 SHALL implement states IDLE and LOCKED, plus registers owner (index), rr_ptr (index), timer.
REQ-010 In IDLE, SHALL select the winner combinationally as the first i with req_valid[i]=1 searching from rr_ptr upward, wrapping NUM_REQ-1 to 0.
REQ-011 In LOCKED, SHALL consider only owner; all other requesters are ignored regardless of req_valid.
REQ-012 SHALL drive out_req_valid/addr/wen/wdata from the selected requester in the same cycle (zero latency); out_req_valid=0 when none selected.
REQ-013 SHALL drive req_ready[sel]=out_req_ready and req_ready[j]=0 for every other j.
REQ-014 A handshake SHALL be out_req_valid & out_req_ready; no request is buffered, dropped or duplicated.
REQ-015 On an IDLE write handshake with wdata[7:0]!=0x0A, SHALL enter LOCKED with owner=winner and timer=0.
REQ-016 On any write handshake with wdata[7:0]==0x0A, SHALL go to (or stay in) IDLE and set rr_ptr=(sel+1) mod NUM_REQ.
REQ-017 On a read handshake (wen=0), SHALL not change state, owner or rr_ptr; timer resets to 0 if LOCKED.
REQ-018 In LOCKED, on an owner write handshake without 0x0A, SHALL stay LOCKED with timer=0.
REQ-019 In LOCKED without owner handshake, SHALL increment timer; when timer==LOCK_TIMEOUT-1, SHALL enter IDLE next cycle with rr_ptr=(owner+1) mod NUM_REQ.
REQ-020 Timer SHALL be $clog2(LOCK_TIMEOUT+1) bits wide and never wrap.
REQ-021 SHALL set resp_valid[sel]=out_resp_valid in the handshake cycle, resp_valid[j]=0 otherwise; resp_rdata[*]=out_resp_rdata for all requesters.
REQ-022 Owner handshake and timeout in the same cycle SHALL resolve to handshake (REQ-015..018 take precedence).

Reset
REQ-023 On reset=1 at posedge clk, SHALL set state=IDLE, owner=0, rr_ptr=0, timer=0, dropping any lock mid-line.
REQ-024 While reset=1, SHALL hold out_req_valid=0, all req_ready=0, all resp_valid=0.

Structure
REQ-025 UIntX and UInt8 SHALL come from the existing shared basic types; the state enum UartArbState (IDLE, LOCKED) SHALL be added to the shared package.
REQ-026 Round-robin selection SHALL be one sub-module, rr_picker (inputs valid vector, pointer; outputs found, index).
REQ-027 Arbiter SHALL sit between the hart MMIO ports and the existing UART TX MMIO slave without changing that slave.

Verification
REQ-028 Reset, then req_valid=2'b11, both write 0x41, out_req_ready=1 -> req 0 granted, state LOCKED owner=0, req_ready[1]=0.
REQ-029 Owner 0 writes "H","i",0x0A while req 1 holds valid -> exactly H,i,LF downstream, then req 1 granted next cycle (rr_ptr=1).
REQ-030 LOCK_TIMEOUT=4, owner 0 writes 0x41 then idles, req 1 valid -> req 1 granted exactly 4 cycles after 0x41 handshake.
REQ-031 out_req_ready=0 for 5 cycles with req 0 valid -> out_req_valid=1 stable, no handshake, timer advances only if owner idle is defined as no handshake; release on first ready cycle.
REQ-032 Reset asserted in LOCKED with owner=1 -> next cycle IDLE, rr_ptr=0, req 0 wins simultaneous request.
REQ-033 Read (wen=0) by req 1 in IDLE -> forwarded, resp_valid[1]=1, resp_valid[0]=0, state stays IDLE.
